tt_um_asiclab_sum_collector: RTL
================================

// Module: tt_um_asiclab_sum_collector
// PURPOSE
//   Receive end of the nibble-adder result interface. A producer presents a 5-bit sum
//   (carry + 4-bit sum) on ui_in[4:0] and strobes ui_in[5].
//   This tile captures the results into a small FIFO and lets an external reader pop
//   them with ui_in[6].
//   Head-of-queue data and status appear on uo_out; the fill count appears on uio_out.
//   Standard Tiny Tapeout user-tile wrapper.
// PARAMETERS
//   DATA_W  5  width of a captured result (4-bit sum + carry)
//   DEPTH   8  FIFO entries; power of two, 2..8 (count field is 4 bits)
// PORTS
//   clk      in   1  tile clock; all state is on the rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   ena      in   1  unused (always 1)
//   ui_in    in   8  [4:0] data, [5] wr_strobe, [6] rd_strobe, [7] clr
//   uo_out   out  8  [4:0] head data, [5] not_empty, [6] full, [7] err (sticky)
//   uio_in   in   8  unused
//   uio_out  out  8  [3:0] count, [7:4] checksum nibble (see CONFIGURATION)
//   uio_oe   out  8  constant 8'hFF (all uio pins are outputs)
// BEHAVIOUR
//   - Reset (rst_n=0, async): FIFO empty, wr/rd pointers 0, count 0, err 0, checksum 0.
//     All synchronizer flops are 0. uo_out=8'h00, uio_out=8'h00.
//   - ui_in[7:5] and ui_in[4:0] pass through a 2-flop synchronizer (s1, s2).
//     strobe/clr are also kept in a third flop s3 for edge detection.
//   - push = s2[5] & ~s3[5] (rising edge); pop = s2[6] & ~s3[6]; clr = s2[7] (level).
//   - Latency: a pin change before edge k commits to the FIFO/count at edge k+2.
//     Outputs show the new state immediately after edge k+2.
//     Data must be stable >=2 cycles before the wr_strobe rise.
//   - Priority per cycle: clr > {push, pop}.
//     clr=1 empties the FIFO and clears count, err and checksum every cycle it is high.
//   - push & !full: mem[wp] <= s2 data; wp++ (wraps mod DEPTH); count++.
//   - push & full & !pop: data dropped; err <= 1.
//   - pop & !empty: rp++ (wraps); count--.
//   - pop & empty: ignored; err <= 1. No bypass: a push in the same cycle still only writes.
//   - push & pop, not empty: both occur; count unchanged, including when full.
//   - Head data = mem[rp] when not empty, else 5'b0. Outputs are driven from registers/mem.
//     No combinational path from ui_in to uo_out.
//   - err stays 1 until clr or reset.
// CONFIGURATION
//   COLLECTOR_CKSUM_EN defined: a 4-bit running sum of data[3:0] of every accepted push
//     (mod 16) drives uio_out[7:4]. It is cleared by clr/reset. Dropped pushes do not count.
//   COLLECTOR_CKSUM_EN undefined: no checksum register; uio_out[7:4] = 4'b0.
// STRUCTURE
//   - Package asiclab_collector_pkg: DATA_W, DEPTH, and pin-index localparams
//     (DATA_LSB=0, WR_BIT=5, RD_BIT=6, CLR_BIT=7, NE_BIT=5, FULL_BIT=6, ERR_BIT=7).
//   - Sub-module tt_asiclab_sync_edge: 2-flop synchronizer plus rising-edge detect.
//     Instantiated once per strobe (wr, rd). clr uses only its level output.
//   - FIFO pointers, count, err and checksum live in the top module. Memory is a flop array.
// TESTING
//   1. Reset → uo_out=00, uio_out=00, uio_oe=FF.
//      Hold data=5'h13 and pulse wr → at edge k+2: uo_out=8'h33, uio_out[3:0]=1.
//   2. Push 5'h01..5'h08 (8 pulses) → full=1, count=8.
//      9th push of 5'h1F → err=1, count stays 8, head still 5'h01.
//   3. Pop 8 times from full → data 01..08 in order; final not_empty=0, head=0.
//      9th pop → err=1.
//   4. With count=3, raise wr and rd on the same clock → count stays 3.
//      Head advances to the 2nd entry; new data lands at the tail.
//   5. Hold clr high during a push → no write, count=0, err=0.
//      Release clr; push 5'h0A → count=1.
//   6. COLLECTOR_CKSUM_EN: push 5'h19, 5'h0C → uio_out[7:4]=4'h5 (9+C mod 16).
//      Undefined → 4'h0.
//      Also assert rst_n low mid-push: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/asiclab_collector_pkg.sv
// Shared sizes and pin map for the nibble-sum collector tile.
// Optional feature macro: COLLECTOR_CKSUM_EN.
package asiclab_collector_pkg;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  localparam int DATA_LSB = 0;
  localparam int WR_BIT   = 5;
  localparam int RD_BIT   = 6;
  localparam int CLR_BIT  = 7;

  localparam int NE_BIT   = 5;
  localparam int FULL_BIT = 6;
  localparam int ERR_BIT  = 7;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/tt_asiclab_sync_edge.sv
// Two-flop synchronizer for one strobe pin.
// A third flop provides rising-edge detection.
module tt_asiclab_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/tt_um_asiclab_sum_collector.sv
// Collects strobed 5-bit sums into a FIFO popped by an external reader.
// Define COLLECTOR_CKSUM_EN to drive a running nibble checksum on uio_out[7:4].
module tt_um_asiclab_sum_collector
  import asiclab_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  data_t d_s1;
  data_t d_s2;
  logic  c_s1;
  logic  c_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1 <= '0;
      d_s2 <= '0;
      c_s1 <= 1'b0;
      c_s2 <= 1'b0;
    end else begin
      d_s1 <= ui_in[DATA_LSB +: DATA_W];
      d_s2 <= d_s1;
      c_s1 <= ui_in[CLR_BIT];
      c_s2 <= c_s1;
    end
  end

  logic push;
  logic pop;
  logic wr_lvl;
  logic rd_lvl;
  logic clr;

  tt_asiclab_sync_edge u_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[WR_BIT]),
    .level (wr_lvl),
    .rise  (push)
  );

  tt_asiclab_sync_edge u_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[RD_BIT]),
    .level (rd_lvl),
    .rise  (pop)
  );

  assign clr = c_s2;

  data_t mem [DEPTH];
  ptr_t  wp;
  ptr_t  rp;
  cnt_t  count;
  logic  err;
  logic  empty;
  logic  full;
  logic  do_push;
  logic  do_pop;
  logic  bad;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A full FIFO still accepts a push when a pop frees a slot that cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign bad     = (push & ~do_push) | (pop & empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wp] <= d_s2;
        wp      <= wp + PTR_W'(1);
      end
      if (do_pop)
        rp <= rp + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bad)
        err <= 1'b1;
    end
  end

  logic [3:0] cksum;

`ifdef COLLECTOR_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cksum <= 4'h0;
    else if (clr)
      cksum <= 4'h0;
    else if (do_push)
      cksum <= cksum + d_s2[3:0];
  end
`else
  assign cksum = 4'h0;
`endif

  data_t head;

  assign head = empty ? '0 : mem[rp];

  always_comb begin
    uo_out                    = 8'h00;
    uo_out[DATA_LSB +: DATA_W] = head;
    uo_out[NE_BIT]            = ~empty;
    uo_out[FULL_BIT]          = full;
    uo_out[ERR_BIT]           = err;
  end

  assign uio_out = {cksum, count};
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, wr_lvl, rd_lvl};

endmodule
